alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have parameter MUL_CYCLES, default 2: EXEC cycles allowed for op 011 (mul), legal range 1..16.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 4: EXEC cycles allowed for op 010 (div), legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, 1, request present.
REQ-006 The block SHALL have port req_ready, output, 1, request accepted this cycle when high together with req_valid.
REQ-007 The block SHALL have ports req_a and req_b, input, 32 each, operands.
REQ-008 The block SHALL have port req_op, input, 3, operation: 000 add, 001 sub, 010 div, 011 mul, 1xx illegal.
REQ-009 The block SHALL have port req_tag, input, 5, destination tag returned unchanged with the response.
REQ-010 The block SHALL have ports alu_rs1 and alu_rs2, output, 32 each, registered operands to the combinational ALU.
REQ-011 The block SHALL have port alu_op_ctrl, output, 3, registered ALU operation select.
REQ-012 The block SHALL have ports alu_result, input, 32, and alu_zero, input, 1: ALU result and its zero flag.
REQ-013 The block SHALL have port rsp_valid, output, 1, response present.
REQ-014 The block SHALL have port rsp_ready, input, 1, consumer accepts the response.
REQ-015 The block SHALL have ports rsp_result (32), rsp_zero (1), rsp_tag (5), rsp_err (1), all outputs, registered response fields.
REQ-016 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, EXEC, RESP.
REQ-018 req_ready SHALL be high in IDLE, and in RESP when rsp_ready is high; low otherwise.
REQ-019 On acceptance, the block SHALL register req_a, req_b, req_op and req_tag into alu_rs1, alu_rs2, alu_op_ctrl and the tag register, load the latency counter with LAT-1, and move to EXEC.
REQ-020 LAT SHALL be 1 for add, sub and illegal ops, MUL_CYCLES for mul, and DIV_CYCLES for div.
REQ-021 In EXEC, the counter SHALL decrement every cycle; at the edge where it equals 0, the block SHALL capture the response fields and move to RESP.
REQ-022 rsp_valid SHALL rise exactly LAT rising edges after the accepting edge and SHALL stay high, with all rsp_* fields stable, until rsp_valid and rsp_ready are both high.
REQ-023 For legal ops, rsp_result SHALL equal alu_result and rsp_zero SHALL equal alu_zero at the capture edge.
REQ-024 For a div with a divisor of 0, rsp_err SHALL be 1 and rsp_result SHALL pass the ALU value through (expected FFFFFFFF).
REQ-025 For illegal ops, rsp_result SHALL be 0, rsp_zero 1 and rsp_err 1; alu_op_ctrl SHALL be loaded with 000 and the operands with 0.
REQ-026 rsp_err SHALL be 0 for all other cases.
REQ-027 On RESP with rsp_ready high, the block SHALL go to IDLE if req_valid is low; otherwise it SHALL accept the new request the same cycle and go directly to EXEC, with no bubble.
REQ-028 Response registers SHALL change only at a capture edge.
REQ-029 alu_rs1, alu_rs2 and alu_op_ctrl SHALL change only on acceptance and SHALL be held for the whole of EXEC, which is the multicycle-path guarantee for mul and div.
REQ-030 In EXEC, req_ready SHALL be low and req_* SHALL be ignored.
REQ-031 rsp_ready without rsp_valid SHALL have no effect.

Reset
REQ-032 While rst is high, the block SHALL force state IDLE and counter 0.
REQ-033 While rst is high, alu_rs1, alu_rs2 and alu_op_ctrl SHALL be 0, rsp_valid, rsp_result, rsp_zero, rsp_tag and rsp_err SHALL be 0, and busy SHALL be 0.
REQ-034 Reset asserted mid-EXEC or mid-RESP SHALL discard the in-flight operation with no response; the first request after rst deasserts SHALL be accepted normally.

Verification
REQ-035 The bench SHALL cover: add a=5 b=7 tag=3, rsp_ready=1 -> rsp_valid 1 edge after accept, result 12, zero 0, tag 3, err 0.
REQ-036 The bench SHALL cover: sub a=9 b=9 -> result 0, zero 1; mul a=6 b=7 with default parameters -> rsp_valid exactly 2 edges after accept, result 42.
REQ-037 The bench SHALL cover: div a=100 b=0 -> rsp_valid 4 edges after accept, result FFFFFFFF, err 1; div a=100 b=7 -> result 14, err 0.
REQ-038 The bench SHALL cover: op 101 -> result 0, zero 1, err 1, latency 1; the ALU is never driven with 101.
REQ-039 The bench SHALL cover: rsp_ready held low 5 cycles -> response stable, req_ready 0; then rsp_ready with req_valid high -> next request accepted the same cycle.
REQ-040 The bench SHALL cover: rst pulsed during a div's EXEC -> rsp_valid never asserts, all outputs 0; a following add 1+1 -> result 2.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/response controller for a shared combinational ALU: latches one request,
// holds its operands for an op-dependent number of cycles, then presents a registered response.
module alu_issue_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_tag,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    output logic [2:0]  alu_op_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_zero,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic [4:0]  rsp_tag,
    output logic        rsp_err,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [2:0] OP_DIV = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

    // Counter preload: number of EXEC cycles minus one for the given op.
    function automatic logic [3:0] last_count(input logic [2:0] op);
        case (op)
            OP_MUL:  return MUL_LAST;
            OP_DIV:  return DIV_LAST;
            default: return 4'd0;
        endcase
    endfunction

    // Final response fields {err, zero, result}; illegal ops never trust the ALU.
    function automatic logic [33:0] resolve(input logic        illegal,
                                            input logic        div_zero,
                                            input logic [31:0] result,
                                            input logic        zero);
        if (illegal)
            return {1'b1, 1'b1, 32'd0};
        return {div_zero, zero, result};
    endfunction

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        illegal_p0;
    logic        div_p0;
    logic [4:0]  tag_p0;
    logic        accept;
    logic        req_illegal;
    logic [33:0] rsp_fields;

    assign req_ready   = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept      = req_valid && req_ready;
    assign req_illegal = req_op[2];
    assign busy        = (state != IDLE);
    assign rsp_fields  = resolve(illegal_p0, div_p0 && (alu_rs2 == 32'd0), alu_result, alu_zero);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            illegal_p0  <= 1'b0;
            div_p0      <= 1'b0;
            tag_p0      <= 5'd0;
            alu_rs1     <= 32'd0;
            alu_rs2     <= 32'd0;
            alu_op_ctrl <= 3'd0;
            rsp_valid   <= 1'b0;
            rsp_result  <= 32'd0;
            rsp_zero    <= 1'b0;
            rsp_tag     <= 5'd0;
            rsp_err     <= 1'b0;
        end else if (accept) begin
            // Accept stage: operands are frozen here for the whole EXEC window.
            alu_rs1     <= req_illegal ? 32'd0 : req_a;
            alu_rs2     <= req_illegal ? 32'd0 : req_b;
            alu_op_ctrl <= req_illegal ? 3'd0 : req_op;
            illegal_p0  <= req_illegal;
            div_p0      <= (req_op == OP_DIV);
            tag_p0      <= req_tag;
            cnt         <= last_count(req_op);
            rsp_valid   <= 1'b0;
            state       <= EXEC;
        end else begin
            case (state)
                EXEC: begin
                    // Capture stage: response registers only ever load here.
                    if (cnt == 4'd0) begin
                        rsp_err    <= rsp_fields[33];
                        rsp_zero   <= rsp_fields[32];
                        rsp_result <= rsp_fields[31:0];
                        rsp_tag    <= tag_p0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                IDLE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU drives the datapath inputs and an
// operation-level model predicts latency and response fields for each request.
module tb_alu_issue_ctrl;

    localparam int MUL_CYC = 2;
    localparam int DIV_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic [4:0]  req_tag;
    logic [31:0] alu_rs1;
    logic [31:0] alu_rs2;
    logic [2:0]  alu_op_ctrl;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [4:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_res, exp_rs1, exp_rs2;
    logic [2:0]  exp_opc;
    logic        exp_zero, exp_err;
    logic [4:0]  exp_tag;
    int          exp_lat;

    alu_issue_ctrl #(.MUL_CYCLES(MUL_CYC), .DIV_CYCLES(DIV_CYC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_op_ctrl(alu_op_ctrl),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Combinational ALU; a 1xx select would show up as a recognisable junk value.
    always_comb begin
        alu_result = 32'hDEADBEEF;
        case (alu_op_ctrl)
            3'b000: alu_result = alu_rs1 + alu_rs2;
            3'b001: alu_result = alu_rs1 - alu_rs2;
            3'b010: alu_result = (alu_rs2 == 32'd0) ? 32'hFFFFFFFF : alu_rs1 / alu_rs2;
            3'b011: alu_result = alu_rs1 * alu_rs2;
            default: alu_result = 32'hDEADBEEF;
        endcase
        alu_zero = (alu_result == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                         input logic [4:0] tag);
        exp_tag = tag;
        exp_err = 1'b0;
        exp_lat = 1;
        exp_rs1 = a;
        exp_rs2 = b;
        exp_opc = op;
        case (op)
            3'd0: exp_res = a + b;
            3'd1: exp_res = a - b;
            3'd2: begin
                exp_lat = DIV_CYC;
                if (b == 0) begin
                    exp_res = 32'hFFFFFFFF;
                    exp_err = 1'b1;
                end else begin
                    exp_res = a / b;
                end
            end
            3'd3: begin
                exp_lat = MUL_CYC;
                exp_res = a * b;
            end
            default: begin
                exp_res = 32'd0;
                exp_err = 1'b1;
                exp_rs1 = 32'd0;
                exp_rs2 = 32'd0;
                exp_opc = 3'd0;
            end
        endcase
        exp_zero = (exp_res == 32'd0);
    endtask

    // Presents a request at posedge+1 and returns one step after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [4:0] tag);
        model(a, b, op, tag);
        req_a = a;
        req_b = b;
        req_op = op;
        req_tag = tag;
        req_valid = 1'b1;
        #1;
        chk("req_ready_before_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        req_op = 3'($urandom_range(0, 7));
        req_tag = 5'($urandom_range(0, 31));
        chk("alu_rs1", alu_rs1, exp_rs1);
        chk("alu_rs2", alu_rs2, exp_rs2);
        chk("alu_op_ctrl", 32'(alu_op_ctrl), 32'(exp_opc));
        chk("busy_after_accept", 32'(busy), 32'd1);
        chk("rsp_valid_after_accept", 32'(rsp_valid), 32'd0);
    endtask

    task automatic wait_rsp();
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (!rsp_valid) begin
                chk("rs1_held", alu_rs1, exp_rs1);
                chk("op_held", 32'(alu_op_ctrl), 32'(exp_opc));
                chk("req_ready_exec", 32'(req_ready), 32'd0);
            end
        end while (!rsp_valid && n < 40);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("rsp_result", rsp_result, exp_res);
        chk("rsp_zero", 32'(rsp_zero), 32'(exp_zero));
        chk("rsp_tag", 32'(rsp_tag), 32'(exp_tag));
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_valid_after_consume", 32'(rsp_valid), 32'd0);
        chk("busy_after_consume", 32'(busy), 32'd0);
    endtask

    task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [4:0] tag);
        send(a, b, op, tag);
        wait_rsp();
        consume();
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  op;

        rst = 1'b1;
        req_valid = 1'b0;
        req_a = 32'd0;
        req_b = 32'd0;
        req_op = 3'd0;
        req_tag = 5'd0;
        rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_alu_rs1", alu_rs1, 32'd0);
        chk("rst_alu_rs2", alu_rs2, 32'd0);
        chk("rst_alu_op", 32'(alu_op_ctrl), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        txn(32'd5, 32'd7, 3'b000, 5'd3);
        txn(32'd9, 32'd9, 3'b001, 5'd4);
        txn(32'd6, 32'd7, 3'b011, 5'd5);
        txn(32'd100, 32'd0, 3'b010, 5'd6);
        txn(32'd100, 32'd7, 3'b010, 5'd7);
        txn(32'd55, 32'd66, 3'b101, 5'd8);

        // Held-off response, then a request accepted in the same cycle it is consumed.
        rsp_ready = 1'b0;
        send(32'd3, 32'd4, 3'b011, 5'd9);
        wait_rsp();
        req_a = 32'd10;
        req_b = 32'd20;
        req_op = 3'b000;
        req_tag = 5'd10;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_rsp_result", rsp_result, 32'd12);
            chk("stall_rsp_tag", 32'(rsp_tag), 32'd9);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_alu_rs1", alu_rs1, 32'd3);
        end
        rsp_ready = 1'b1;
        send(32'd10, 32'd20, 3'b000, 5'd10);
        wait_rsp();
        consume();

        // Reset in the middle of a divide drops it without a response.
        send(32'd100, 32'd3, 3'b010, 5'd11);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_alu_rs1", alu_rs1, 32'd0);
        chk("midrst_alu_rs2", alu_rs2, 32'd0);
        chk("midrst_alu_op", 32'(alu_op_ctrl), 32'd0);
        chk("midrst_rsp_result", rsp_result, 32'd0);
        chk("midrst_rsp_tag", 32'(rsp_tag), 32'd0);
        chk("midrst_rsp_err", 32'(rsp_err), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        txn(32'd1, 32'd1, 3'b000, 5'd12);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = a;
                2: b = 32'($urandom_range(1, 50));
                default: b = $urandom;
            endcase
            txn(a, b, op, 5'($urandom_range(0, 31)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
